// File: rtl/life_controller.sv
// Health HUD sequencer: tracks health, post-hit invulnerability, death and the per-mask
// break animation, updating once per video frame.
module life_controller #(
    parameter int unsigned MAX_HEALTH        = 5,
    parameter int unsigned INVULN_FRAMES     = 60,
    parameter int unsigned BREAK_STEP_FRAMES = 4
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       damage_req,
    input  logic       heal_req,
    input  logic       respawn_req,
    output logic [2:0] health,
    output logic [4:0] mask_full,
    output logic       break_active,
    output logic [2:0] break_idx,
    output logic [1:0] break_frame,
    output logic       invuln,
    output logic       dead,
    output logic       damage_ack,
    output logic       heal_ack
);

    typedef enum logic [1:0] {
        StNormal,
        StInvuln,
        StDead
    } state_e;

    localparam logic [2:0] MaxHealth  = 3'(MAX_HEALTH);
    localparam logic [7:0] InvulnLoad = 8'(INVULN_FRAMES);
    localparam logic [3:0] StepLast   = 4'(BREAK_STEP_FRAMES - 1);
    localparam logic [4:0] MaskReset  = 5'((1 << MAX_HEALTH) - 1);

    state_e     state_q, state_d;
    logic [2:0] health_q, health_d;
    logic [4:0] mask_full_q, mask_full_d;
    logic [7:0] invuln_cnt_q, invuln_cnt_d;
    logic [3:0] step_cnt_q, step_cnt_d;
    logic       break_active_q, break_active_d;
    logic [2:0] break_idx_q, break_idx_d;
    logic [1:0] break_frame_q, break_frame_d;
    logic       invuln_q, invuln_d;
    logic       dead_q, dead_d;
    logic       damage_ack_q, damage_ack_d;
    logic       heal_ack_q, heal_ack_d;

    logic damage_acc;
    logic heal_acc;
    logic respawn_acc;

    always_comb begin
        damage_acc  = (state_q == StNormal) && (health_q != 3'd0) && damage_req;
        // Damage accepted in NORMAL wins over a simultaneous heal.
        heal_acc    = ((state_q == StNormal) || (state_q == StInvuln)) &&
                      (health_q < MaxHealth) && heal_req && !damage_acc;
        respawn_acc = (state_q == StDead) && respawn_req;
    end

    always_comb begin
        state_d        = state_q;
        health_d       = health_q;
        invuln_cnt_d   = invuln_cnt_q;
        step_cnt_d     = step_cnt_q;
        break_active_d = break_active_q;
        break_idx_d    = break_idx_q;
        break_frame_d  = break_frame_q;
        damage_ack_d   = 1'b0;
        heal_ack_d     = 1'b0;
        mask_full_d    = 5'd0;

        if (break_active_q) begin
            if (step_cnt_q == StepLast) begin
                step_cnt_d = 4'd0;
                if (break_frame_q == 2'd3) begin
                    break_active_d = 1'b0;
                    break_frame_d  = 2'd0;
                end else begin
                    break_frame_d = break_frame_q + 2'd1;
                end
            end else begin
                step_cnt_d = step_cnt_q + 4'd1;
            end
        end

        if (state_q == StInvuln) begin
            invuln_cnt_d = invuln_cnt_q - 8'd1;
            if (invuln_cnt_q == 8'd1) begin
                state_d = StNormal;
            end
        end

        if (damage_acc) begin
            health_d       = health_q - 3'd1;
            damage_ack_d   = 1'b1;
            break_idx_d    = health_q - 3'd1;
            break_frame_d  = 2'd0;
            break_active_d = 1'b1;
            step_cnt_d     = 4'd0;
            if (health_q == 3'd1) begin
                state_d      = StDead;
                invuln_cnt_d = 8'd0;
            end else begin
                state_d      = StInvuln;
                invuln_cnt_d = InvulnLoad;
            end
        end

        if (heal_acc) begin
            health_d   = health_q + 3'd1;
            heal_ack_d = 1'b1;
            // Restoring the mask that is mid-break cancels its animation.
            if (break_active_q && (break_idx_q == health_q)) begin
                break_active_d = 1'b0;
                break_frame_d  = 2'd0;
                step_cnt_d     = 4'd0;
            end
        end

        if (respawn_acc) begin
            state_d        = StNormal;
            health_d       = MaxHealth;
            invuln_cnt_d   = 8'd0;
            break_active_d = 1'b0;
            break_frame_d  = 2'd0;
            step_cnt_d     = 4'd0;
        end

        invuln_d = (state_d == StInvuln);
        dead_d   = (state_d == StDead);
        for (int i = 0; i < 5; i++) begin
            mask_full_d[i] = (3'(i) < health_d);
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q        <= StNormal;
            health_q       <= MaxHealth;
            mask_full_q    <= MaskReset;
            invuln_cnt_q   <= 8'd0;
            step_cnt_q     <= 4'd0;
            break_active_q <= 1'b0;
            break_idx_q    <= 3'd0;
            break_frame_q  <= 2'd0;
            invuln_q       <= 1'b0;
            dead_q         <= 1'b0;
            damage_ack_q   <= 1'b0;
            heal_ack_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            health_q       <= health_d;
            mask_full_q    <= mask_full_d;
            invuln_cnt_q   <= invuln_cnt_d;
            step_cnt_q     <= step_cnt_d;
            break_active_q <= break_active_d;
            break_idx_q    <= break_idx_d;
            break_frame_q  <= break_frame_d;
            invuln_q       <= invuln_d;
            dead_q         <= dead_d;
            damage_ack_q   <= damage_ack_d;
            heal_ack_q     <= heal_ack_d;
        end
    end

    assign health       = health_q;
    assign mask_full    = mask_full_q;
    assign break_active = break_active_q;
    assign break_idx    = break_idx_q;
    assign break_frame  = break_frame_q;
    assign invuln       = invuln_q;
    assign dead         = dead_q;
    assign damage_ack   = damage_ack_q;
    assign heal_ack     = heal_ack_q;

endmodule

// File: tb/tb_life_controller.sv
// Directed bench for life_controller with hand-computed expectations.
module tb_life_controller;

    logic       frame_clk;
    logic       Reset;
    logic       damage_req;
    logic       heal_req;
    logic       respawn_req;
    logic [2:0] health;
    logic [4:0] mask_full;
    logic       break_active;
    logic [2:0] break_idx;
    logic [1:0] break_frame;
    logic       invuln;
    logic       dead;
    logic       damage_ack;
    logic       heal_ack;

    int n_checks = 0;
    int n_fail   = 0;

    life_controller #(
        .MAX_HEALTH       (5),
        .INVULN_FRAMES    (60),
        .BREAK_STEP_FRAMES(4)
    ) dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .damage_req  (damage_req),
        .heal_req    (heal_req),
        .respawn_req (respawn_req),
        .health      (health),
        .mask_full   (mask_full),
        .break_active(break_active),
        .break_idx   (break_idx),
        .break_frame (break_frame),
        .invuln      (invuln),
        .dead        (dead),
        .damage_ack  (damage_ack),
        .heal_ack    (heal_ack)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic check_reset_values();
        check_eq("rst_health", health, 5);
        check_eq("rst_mask", mask_full, 5'b11111);
        check_eq("rst_break_active", break_active, 0);
        check_eq("rst_break_idx", break_idx, 0);
        check_eq("rst_break_frame", break_frame, 0);
        check_eq("rst_invuln", invuln, 0);
        check_eq("rst_dead", dead, 0);
        check_eq("rst_damage_ack", damage_ack, 0);
        check_eq("rst_heal_ack", heal_ack, 0);
    endtask

    initial begin
        int n_acks;
        int last_ack;
        int waited;

        Reset       = 1'b1;
        damage_req  = 1'b0;
        heal_req    = 1'b0;
        respawn_req = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_reset_values();

        // Single hit: animation timing and invulnerability length.
        damage_req = 1'b1;
        tick();
        damage_req = 1'b0;
        check_eq("hit_health", health, 4);
        check_eq("hit_mask", mask_full, 5'b01111);
        check_eq("hit_ack", damage_ack, 1);
        check_eq("hit_active", break_active, 1);
        check_eq("hit_idx", break_idx, 4);
        check_eq("hit_frame", break_frame, 0);
        check_eq("hit_invuln", invuln, 1);
        for (int k = 1; k <= 65; k++) begin
            tick();
            check_eq("anim_active", break_active, (k < 16) ? 1 : 0);
            check_eq("anim_frame", break_frame, (k < 16) ? (k / 4) : 0);
            check_eq("invuln_window", invuln, (k < 60) ? 1 : 0);
            check_eq("ack_pulse", damage_ack, 0);
        end

        // Heal back to full, then heal at full is ignored.
        heal_req = 1'b1;
        tick();
        check_eq("heal_ack", heal_ack, 1);
        check_eq("heal_health", health, 5);
        check_eq("heal_mask", mask_full, 5'b11111);
        tick();
        heal_req = 1'b0;
        check_eq("heal_full_ack", heal_ack, 0);
        check_eq("heal_full_health", health, 5);

        // Held damage: one ack every 61 edges down to death.
        n_acks   = 0;
        last_ack = 0;
        damage_req = 1'b1;
        for (int c = 1; c <= 330; c++) begin
            tick();
            if (damage_ack) begin
                n_acks++;
                if (n_acks == 1) check_eq("hold_first_edge", c, 1);
                else check_eq("hold_spacing", c - last_ack, 61);
                check_eq("hold_health", health, 5 - n_acks);
                if (n_acks == 5) begin
                    check_eq("death_dead", dead, 1);
                    check_eq("death_invuln", invuln, 0);
                end
                last_ack = c;
            end
        end
        check_eq("hold_ack_count", n_acks, 5);
        check_eq("dead_health", health, 0);
        check_eq("dead_mask", mask_full, 0);
        check_eq("dead_flag", dead, 1);
        heal_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("dead_heal_ack", heal_ack, 0);
            check_eq("dead_heal_health", health, 0);
            check_eq("dead_damage_ack", damage_ack, 0);
        end
        heal_req   = 1'b0;
        damage_req = 1'b0;

        respawn_req = 1'b1;
        tick();
        respawn_req = 1'b0;
        check_eq("respawn_health", health, 5);
        check_eq("respawn_dead", dead, 0);
        check_eq("respawn_mask", mask_full, 5'b11111);
        check_eq("respawn_invuln", invuln, 0);

        // Get to health 3 with mask 3 animating, inside INVULN.
        damage_req = 1'b1;
        tick();
        damage_req = 1'b0;
        check_eq("setup_health4", health, 4);
        for (int i = 0; i < 60; i++) tick();
        check_eq("setup_invuln_done", invuln, 0);
        damage_req = 1'b1;
        tick();
        damage_req = 1'b0;
        check_eq("setup_health3", health, 3);
        check_eq("setup_idx3", break_idx, 3);
        tick();
        tick();

        // INVULN: heal wins, cancels mask-3 animation, counter keeps running.
        damage_req = 1'b1;
        heal_req   = 1'b1;
        tick();
        damage_req = 1'b0;
        heal_req   = 1'b0;
        check_eq("inv_both_heal_ack", heal_ack, 1);
        check_eq("inv_both_damage_ack", damage_ack, 0);
        check_eq("inv_both_health", health, 4);
        check_eq("inv_both_active", break_active, 0);
        check_eq("inv_both_frame", break_frame, 0);
        check_eq("inv_both_invuln", invuln, 1);
        waited = 0;
        while (invuln && waited < 100) begin
            tick();
            waited++;
        end
        check_eq("inv_remaining", waited, 57);

        // NORMAL: damage wins, heal dropped.
        damage_req = 1'b1;
        heal_req   = 1'b1;
        tick();
        damage_req = 1'b0;
        heal_req   = 1'b0;
        check_eq("nrm_both_damage_ack", damage_ack, 1);
        check_eq("nrm_both_heal_ack", heal_ack, 0);
        check_eq("nrm_both_health", health, 3);
        check_eq("nrm_both_idx", break_idx, 3);

        // Reset mid-INVULN and mid-animation, with requests asserted.
        for (int i = 0; i < 10; i++) tick();
        check_eq("pre_rst_invuln", invuln, 1);
        check_eq("pre_rst_active", break_active, 1);
        check_eq("pre_rst_frame", break_frame, 2);
        Reset      = 1'b1;
        damage_req = 1'b1;
        heal_req   = 1'b1;
        tick();
        heal_req = 1'b0;
        check_reset_values();
        Reset = 1'b0;
        tick();
        damage_req = 1'b0;
        check_eq("post_rst_damage_ack", damage_ack, 1);
        check_eq("post_rst_health", health, 4);
        check_eq("post_rst_invuln", invuln, 1);
        tick();
        check_eq("post_rst_ack_pulse", damage_ack, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
